// File: rtl/regfile_pkg.sv
// Shared definitions for the register file, its access sequencer and their benches.
package regfile_pkg;

  // Default widths; every user must agree with the register file instance.
  localparam int unsigned RF_DATA_WIDTH = 32;
  localparam int unsigned RF_ADDR_WIDTH = 5;

  // Access sequencer states: accept a read, wait for registered data, hold the response.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2
  } seq_state_t;

endpackage

// File: rtl/regfile_hazard_detect.sv
// Combinational hazard and dedup detection between the writeback and operand-fetch streams.
module regfile_hazard_detect #(
  parameter int unsigned ADDR_WIDTH = regfile_pkg::RF_ADDR_WIDTH
) (
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic                  op_use1,
  input  logic                  op_use2,
  input  logic [ADDR_WIDTH-1:0] op_rs1,
  input  logic [ADDR_WIDTH-1:0] op_rs2,
  output logic                  hazard,
  output logic                  dedup
);

  logic hit1;
  logic hit2;

  // A needed source that matches this cycle's write target must wait one cycle so it
  // reads the new value instead of colliding with the write.
  assign hit1   = op_use1 && (op_rs1 == wb_addr);
  assign hit2   = op_use2 && (op_rs2 == wb_addr);
  assign hazard = wb_valid && (hit1 || hit2);

  // Both sources name the same register: read it once on port 1.
  assign dedup  = op_use1 && op_use2 && (op_rs1 == op_rs2);

endmodule

// File: rtl/regfile_access_sequencer.sv
// Merges writeback and operand-fetch streams into collision-free register-file commands
// and returns captured read data through a valid/ready response.
module regfile_access_sequencer
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  // writeback stream
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  // operand-fetch stream
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic                  op_use1,
  input  logic                  op_use2,
  input  logic [ADDR_WIDTH-1:0] op_rs1,
  input  logic [ADDR_WIDTH-1:0] op_rs2,
  // operand response
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data1,
  output logic [DATA_WIDTH-1:0] rsp_data2,
  // register-file command
  output logic                  rf_wen1,
  output logic [ADDR_WIDTH-1:0] rf_wad1,
  output logic [DATA_WIDTH-1:0] rf_din,
  output logic                  rf_ren1,
  output logic [ADDR_WIDTH-1:0] rf_rad1,
  output logic                  rf_ren2,
  output logic [ADDR_WIDTH-1:0] rf_rad2,
  input  logic [DATA_WIDTH-1:0] rf_dout1,
  input  logic [DATA_WIDTH-1:0] rf_dout2,
  input  logic                  rf_collision,
  output logic                  err
);

  seq_state_t            state_q, state_d;
  logic                  hazard;
  logic                  dedup;
  logic                  capture;
  logic                  use1_q;
  logic                  use2_q;
  logic                  dedup_q;
  logic [DATA_WIDTH-1:0] rsp_data1_q;
  logic [DATA_WIDTH-1:0] rsp_data2_q;
  logic                  err_q;

  regfile_hazard_detect #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_hazard (
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .op_use1  (op_use1),
    .op_use2  (op_use2),
    .op_rs1   (op_rs1),
    .op_rs2   (op_rs2),
    .hazard   (hazard),
    .dedup    (dedup)
  );

  // Writes pass straight through and are never stalled.
  assign wb_ready = 1'b1;
  assign rf_wen1  = wb_valid && !reset;
  assign rf_wad1  = wb_addr;
  assign rf_din   = wb_data;
  assign rf_rad1  = op_rs1;
  assign rf_rad2  = op_rs2;

  assign rsp_data1 = rsp_data1_q;
  assign rsp_data2 = rsp_data2_q;
  assign err       = err_q;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (op_ready) state_d = RD_WAIT;
      RD_WAIT: state_d = RSP;
      RSP:     if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; everything is held off while reset is asserted.
  always_comb begin
    op_ready  = 1'b0;
    rf_ren1   = 1'b0;
    rf_ren2   = 1'b0;
    rsp_valid = 1'b0;
    capture   = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          op_ready = op_valid && !hazard;
          rf_ren1  = op_ready && op_use1;
          rf_ren2  = op_ready && op_use2 && !dedup;
        end
        RD_WAIT: capture   = 1'b1;
        RSP:     rsp_valid = 1'b1;
        default: ;
      endcase
    end
  end

  // Request flags latched on accept; read data captured one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      use1_q      <= 1'b0;
      use2_q      <= 1'b0;
      dedup_q     <= 1'b0;
      rsp_data1_q <= '0;
      rsp_data2_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (op_ready) begin
        use1_q  <= op_use1;
        use2_q  <= op_use2;
        dedup_q <= dedup;
      end
      if (capture) begin
        rsp_data1_q <= use1_q ? rf_dout1 : '0;
        // A deduplicated pair only drove port 1, so port 2 data is stale.
        if (dedup_q) begin
          rsp_data2_q <= rf_dout1;
        end else begin
          rsp_data2_q <= use2_q ? rf_dout2 : '0;
        end
        err_q <= err_q | rf_collision;
      end
    end
  end

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Self-checking bench: behavioural register file plus a scoreboard of expected responses.
module tb_regfile_access_sequencer;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic          wb_valid;
  logic          wb_ready;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          op_valid;
  logic          op_ready;
  logic          op_use1;
  logic          op_use2;
  logic [AW-1:0] op_rs1;
  logic [AW-1:0] op_rs2;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data1;
  logic [DW-1:0] rsp_data2;
  logic          rf_wen1;
  logic [AW-1:0] rf_wad1;
  logic [DW-1:0] rf_din;
  logic          rf_ren1;
  logic [AW-1:0] rf_rad1;
  logic          rf_ren2;
  logic [AW-1:0] rf_rad2;
  logic [DW-1:0] rf_dout1;
  logic [DW-1:0] rf_dout2;
  logic          rf_collision;
  logic          err;

  regfile_access_sequencer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_use1      (op_use1),
    .op_use2      (op_use2),
    .op_rs1       (op_rs1),
    .op_rs2       (op_rs2),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data1    (rsp_data1),
    .rsp_data2    (rsp_data2),
    .rf_wen1      (rf_wen1),
    .rf_wad1      (rf_wad1),
    .rf_din       (rf_din),
    .rf_ren1      (rf_ren1),
    .rf_rad1      (rf_rad1),
    .rf_ren2      (rf_ren2),
    .rf_rad2      (rf_rad2),
    .rf_dout1     (rf_dout1),
    .rf_dout2     (rf_dout2),
    .rf_collision (rf_collision),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file: registered reads of the old contents, collision flag
  // reported alongside the read data, plus a bench-controlled collision override.
  logic [DW-1:0] mem [32] = '{default: '0};
  logic          coll_q = 1'b0;
  logic          force_coll;
  logic [DW-1:0] dout1_q = '0;
  logic [DW-1:0] dout2_q = '0;

  always @(posedge clk) begin
    if (rf_ren1) dout1_q <= mem[rf_rad1];
    if (rf_ren2) dout2_q <= mem[rf_rad2];
    coll_q <= rf_wen1 && ((rf_ren1 && rf_rad1 == rf_wad1) || (rf_ren2 && rf_rad2 == rf_wad1));
    if (rf_wen1) mem[rf_wad1] <= rf_din;
  end

  assign rf_dout1     = dout1_q;
  assign rf_dout2     = dout2_q;
  assign rf_collision = coll_q | force_coll;

  typedef struct packed {
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
  } rsp_t;

  rsp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic last_ren1;
  logic last_ren2;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic wb_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  // One operand fetch; hold > 0 keeps rsp_ready low for that many response cycles while
  // writing the same register and offering another request.
  task automatic run_op(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic u1, input logic u2,
                        input logic [DW-1:0] e1, input logic [DW-1:0] e2, input int hold);
    logic acc;
    logic got;
    int   lat;
    rsp_t exp;
    op_rs1   = rs1;
    op_rs2   = rs2;
    op_use1  = u1;
    op_use2  = u2;
    op_valid = 1'b1;
    acc      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (op_ready) begin
        acc       = 1'b1;
        last_ren1 = rf_ren1;
        last_ren2 = rf_ren2;
        break;
      end
      @(posedge clk); #1;
    end
    check("accept", {31'b0, acc}, 1);
    if (!acc) begin
      op_valid = 1'b0;
      return;
    end
    sb.push_back('{d1: e1, d2: e2});
    @(posedge clk); #1;
    op_valid = 1'b0;
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    check("rsp_seen", {31'b0, got}, 1);
    check("latency", lat, 2);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        wb_valid = 1'b1;
        wb_addr  = rs1;
        wb_data  = ~e1;
        op_use1  = 1'b0;
        op_use2  = 1'b0;
        op_valid = 1'b1;
        @(negedge clk);
        check("bp_valid", {31'b0, rsp_valid}, 1);
        check("bp_data1", rsp_data1, e1);
        check("bp_data2", rsp_data2, e2);
        check("bp_op_ready", {31'b0, op_ready}, 0);
      end
      @(posedge clk); #1;
      wb_valid  = 1'b0;
      op_valid  = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
    end
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      check("rsp_data1", rsp_data1, exp.d1);
      check("rsp_data2", rsp_data2, exp.d2);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("rsp_drop", {31'b0, rsp_valid}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    force_coll = 1'b0;
    wb_valid   = 1'b1;
    wb_addr    = 5'd3;
    wb_data    = 32'h1111_1111;
    op_valid   = 1'b1;
    op_use1    = 1'b1;
    op_use2    = 1'b1;
    op_rs1     = 5'd1;
    op_rs2     = 5'd2;
    rsp_ready  = 1'b1;
    last_ren1  = 1'b0;
    last_ren2  = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    check("rst_data1", rsp_data1, 0);
    check("rst_data2", rsp_data2, 0);
    check("rst_err", {31'b0, err}, 0);
    check("rst_wen", {31'b0, rf_wen1}, 0);
    check("rst_ren1", {31'b0, rf_ren1}, 0);
    check("rst_ren2", {31'b0, rf_ren2}, 0);
    check("rst_op_ready", {31'b0, op_ready}, 0);
    check("wb_ready", {31'b0, wb_ready}, 1);
    @(posedge clk); #1;
    reset    = 1'b0;
    wb_valid = 1'b0;
    op_valid = 1'b0;
    @(posedge clk); #1;

    // T1 write then read
    wb_write(5'd5, 32'hDEAD_BEEF);
    run_op(5'd5, 5'd6, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0, 0);
    check("t1_ren2", {31'b0, last_ren2}, 1);

    // No sources used: zeros, no reads
    run_op(5'd5, 5'd6, 1'b0, 1'b0, 32'h0, 32'h0, 0);
    check("z_ren1", {31'b0, last_ren1}, 0);
    check("z_ren2", {31'b0, last_ren2}, 0);

    // T3 dedup
    wb_write(5'd9, 32'hA5A5_A5A5);
    run_op(5'd9, 5'd9, 1'b1, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0);
    check("t3_ren1", {31'b0, last_ren1}, 1);
    check("t3_ren2", {31'b0, last_ren2}, 0);
    check("t3_err", {31'b0, err}, 0);

    // T2 hazard: write and read of x7 in the same cycle
    wb_valid = 1'b1;
    wb_addr  = 5'd7;
    wb_data  = 32'h0000_1234;
    op_valid = 1'b1;
    op_rs1   = 5'd7;
    op_rs2   = 5'd0;
    op_use1  = 1'b1;
    op_use2  = 1'b0;
    @(negedge clk);
    check("t2_op_ready", {31'b0, op_ready}, 0);
    check("t2_wen", {31'b0, rf_wen1}, 1);
    check("t2_ren1", {31'b0, rf_ren1}, 0);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    run_op(5'd7, 5'd0, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 0);
    check("t2_err", {31'b0, err}, 0);

    // T4 backpressure with concurrent writes to the read register
    rsp_ready = 1'b0;
    run_op(5'd5, 5'd9, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hA5A5_A5A5, 5);
    run_op(5'd5, 5'd0, 1'b1, 1'b0, ~32'hDEAD_BEEF, 32'h0, 0);

    // T6 collision during capture sets a sticky error
    force_coll = 1'b1;
    @(negedge clk);
    check("t6_err_idle", {31'b0, err}, 0);
    @(posedge clk); #1;
    run_op(5'd9, 5'd9, 1'b1, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0);
    force_coll = 1'b0;
    check("t6_err_set", {31'b0, err}, 1);
    run_op(5'd7, 5'd0, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 0);
    check("t6_err_sticky", {31'b0, err}, 1);

    // T5 reset while waiting for read data
    op_valid = 1'b1;
    op_rs1   = 5'd9;
    op_use1  = 1'b1;
    op_use2  = 1'b0;
    @(negedge clk);
    check("t5_accept", {31'b0, op_ready}, 1);
    @(posedge clk); #1;
    reset    = 1'b1;
    wb_valid = 1'b1;
    wb_addr  = 5'd3;
    #1;
    check("t5_rsp_valid", {31'b0, rsp_valid}, 0);
    check("t5_err", {31'b0, err}, 0);
    check("t5_wen", {31'b0, rf_wen1}, 0);
    check("t5_ren1", {31'b0, rf_ren1}, 0);
    check("t5_op_ready", {31'b0, op_ready}, 0);
    @(posedge clk); #1;
    reset    = 1'b0;
    wb_valid = 1'b0;
    op_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_no_rsp", {31'b0, rsp_valid}, 0);
      @(posedge clk); #1;
    end

    // Normal operation after reset
    run_op(5'd9, 5'd5, 1'b1, 1'b1, 32'hA5A5_A5A5, ~32'hDEAD_BEEF, 0);
    check("post_err", {31'b0, err}, 0);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
